// File: rtl/ahb_lite_slave.sv
// AHB-Lite memory slave: zero-wait-state accesses to an internal word memory,
// with a two-cycle ERROR response for illegal size, alignment or range.
module ahb_lite_slave #(
  parameter int MEM_WORDS = 64
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [1:0]  HTRANS,
  input  logic        HMASTLOCK,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int          IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [29:0] LIMIT = 30'(MEM_WORDS);

  typedef enum logic [1:0] {
    OKAY_IDLE = 2'b00,
    ERR1      = 2'b01,
    ERR2      = 2'b10
  } state_t;

  state_t state, state_nxt;

  logic [MEM_WORDS-1:0][31:0] mem;

  logic             accept_p0;
  logic             legal_p0;
  logic             vld_p1;
  logic             write_p1;
  logic [1:0]       size_p1;
  logic [1:0]       lane_p1;
  logic [IDX_W-1:0] idx_p1;
  logic [3:0]       be_p1;

  // Burst, protection and lock attributes carry no meaning for a plain memory.
  logic unused_ok;
  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK};

  // Size must be byte/half/word, naturally aligned, and the word inside the memory.
  function automatic logic is_legal(input logic [2:0] size, input logic [31:0] addr);
    logic size_ok, align_ok, range_ok;
    size_ok  = (size <= 3'b010);
    align_ok = (size == 3'b001) ? ~addr[0] :
               (size == 3'b010) ? (addr[1:0] == 2'b00) : 1'b1;
    range_ok = (addr[31:2] < LIMIT);
    return size_ok & align_ok & range_ok;
  endfunction

  // Little-endian byte enables for the registered size and byte offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] m;
    case (size)
      2'b00:   m = 4'b0001 << lane;
      2'b01:   m = lane[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // ---- address phase (p0) ----
  // While ERR1 holds HREADY low the address phase is ignored; the state term
  // keeps that true even if HREADY is not looped back from HREADYOUT.
  assign accept_p0 = HSEL & HREADY & HTRANS[1] & (state != ERR1);
  assign legal_p0  = is_legal(HSIZE, HADDR);

  // ---- data phase (p1) ----
  // Pending-transfer flag: set only for accepted legal transfers.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= accept_p0 & legal_p0;
    end
  end

  // Address-phase attributes captured for use during the data phase.
  always_ff @(posedge HCLK) begin
    if (accept_p0) begin
      write_p1 <= HWRITE;
      size_p1  <= HSIZE[1:0];
      lane_p1  <= HADDR[1:0];
      idx_p1   <= HADDR[IDX_W+1:2];
    end
  end

  assign be_p1 = lane_mask(size_p1, lane_p1);

  // Memory: cleared on reset, byte-lane write at the end of a write data phase.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      mem <= '0;
    end else if (vld_p1 && write_p1) begin
      for (int b = 0; b < 4; b++) begin
        if (be_p1[b]) begin
          mem[idx_p1][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
  end

  // Response state register.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state <= OKAY_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next response state and data-phase outputs.
  always_comb begin
    state_nxt = OKAY_IDLE;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = 32'h0;
    case (state)
      ERR1: begin
        state_nxt = ERR2;
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      ERR2: begin
        HRESP = 1'b1;
        if (accept_p0 && !legal_p0) state_nxt = ERR1;
      end
      default: begin
        if (accept_p0 && !legal_p0) state_nxt = ERR1;
        // A write ending last cycle is already in mem, so reads never see stale data.
        if (vld_p1 && !write_p1) HRDATA = mem[idx_p1];
      end
    endcase
  end

endmodule

// File: tb/tb_ahb_lite_slave.sv
// Bench for ahb_lite_slave: directed scenarios plus random traffic compared
// against a byte-array model of the memory and bus response rules.
module tb_ahb_lite_slave;

  localparam int MW = 64;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  int n_asserts = 0;
  int n_fail    = 0;

  // Reference memory as bytes, plus the write whose data phase is in flight.
  logic [7:0]  mm [0:4*MW-1];
  bit          pend_wr;
  logic [31:0] pend_addr;
  logic [2:0]  pend_size;
  logic [31:0] pend_wdata;

  always #5 HCLK = ~HCLK;

  ahb_lite_slave #(.MEM_WORDS(MW)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HPROT     (HPROT),
    .HTRANS    (HTRANS),
    .HMASTLOCK (HMASTLOCK),
    .HREADY    (HREADYOUT),
    .HWDATA    (HWDATA),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .HRDATA    (HRDATA)
  );

  function automatic bit legal(input logic [2:0] size, input logic [31:0] addr);
    if (size > 3'd2) return 1'b0;
    if ((addr % (32'd1 << size)) != 0) return 1'b0;
    return (addr / 4) < MW;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    int w;
    w = int'(addr / 4) * 4;
    return {mm[w+3], mm[w+2], mm[w+1], mm[w]};
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata);
    int a;
    for (int k = 0; k < (1 << size); k++) begin
      a = int'(addr) + k;
      mm[a] = wdata[8*(a%4) +: 8];
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4*MW; i++) mm[i] = 8'h00;
    pend_wr = 1'b0;
  endtask

  task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One address phase; checks the following cycle, and the ERROR pair if illegal.
  task automatic issue(input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [2:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata, input string tag);
    bit acc, leg;
    logic [33:0] exp;
    HSEL = sel; HTRANS = trans; HWRITE = wr; HSIZE = size; HADDR = addr;
    HWDATA = pend_wdata;
    HBURST = 3'($urandom); HPROT = 4'($urandom); HMASTLOCK = 1'($urandom);
    @(posedge HCLK);
    if (pend_wr) model_write(pend_addr, pend_size, pend_wdata);
    pend_wr = 1'b0;
    acc = sel && trans[1];
    leg = legal(size, addr);
    #1;
    if (!acc)      exp = {2'b10, 32'h0};
    else if (!leg) exp = {2'b01, 32'h0};
    else           exp = {2'b10, wr ? 32'h0 : model_read(addr)};
    check(tag, {HREADYOUT, HRESP, HRDATA}, exp);
    if (acc && leg && wr) begin
      pend_wr = 1'b1; pend_addr = addr; pend_size = size; pend_wdata = wdata;
    end
    if (acc && !leg) begin
      // A legal write presented during ERR1 must be ignored.
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'b010; HADDR = 32'h0;
      HWDATA = 32'hDEADBEEF;
      @(posedge HCLK);
      #1;
      check({tag, "_err2"}, {HREADYOUT, HRESP, HRDATA}, {2'b11, 32'h0});
    end
  endtask

  task automatic idle(input string tag);
    issue(1'b0, 2'b00, 1'b0, 3'b010, 32'h0, 32'h0, tag);
  endtask

  initial begin
    logic [2:0]  sz;
    logic [31:0] ad;
    int          k;
    pend_wdata = 32'h0;
    HSEL = 0; HTRANS = 0; HWRITE = 0; HSIZE = 0; HADDR = 0; HWDATA = 0;
    HBURST = 0; HPROT = 0; HMASTLOCK = 0;

    // Reset
    HRESETn = 1'b0;
    @(posedge HCLK);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    model_clear();
    check("reset_out", {HREADYOUT, HRESP, HRDATA}, {2'b10, 32'h0});
    issue(1, 2'b10, 0, 3'b010, 32'h00, 32'h0, "reset_rd0");
    check("reset_rd0_const", {HREADYOUT, HRESP, HRDATA}, {2'b10, 32'h0});

    // Halfword write then byte and word reads of the same word
    issue(1, 2'b10, 1, 3'b001, 32'h00, 32'h000000AA, "hw_wr0");
    issue(1, 2'b10, 0, 3'b000, 32'h02, 32'h0, "b_rd2");
    check("b_rd2_const", {HREADYOUT, HRESP, HRDATA}, {2'b10, 32'h000000AA});
    issue(1, 2'b11, 0, 3'b010, 32'h00, 32'h0, "w_rd0");
    check("w_rd0_const", {HREADYOUT, HRESP, HRDATA}, {2'b10, 32'h000000AA});

    // Word and byte-lane writes
    issue(1, 2'b10, 1, 3'b010, 32'h04, 32'h0000FFFF, "w_wr4");
    issue(1, 2'b10, 1, 3'b000, 32'h08, 32'h000000AA, "b_wr8");
    issue(1, 2'b11, 1, 3'b000, 32'h09, 32'h00005500, "b_wr9");
    issue(1, 2'b10, 0, 3'b010, 32'h04, 32'h0, "w_rd4");
    check("w_rd4_const", {HREADYOUT, HRESP, HRDATA}, {2'b10, 32'h0000FFFF});
    issue(1, 2'b10, 0, 3'b010, 32'h08, 32'h0, "w_rd8");
    check("w_rd8_const", {HREADYOUT, HRESP, HRDATA}, {2'b10, 32'h000055AA});

    // Write immediately followed by a read of the same word
    issue(1, 2'b10, 1, 3'b010, 32'h0C, 32'h12345678, "w_wrC");
    issue(1, 2'b10, 0, 3'b010, 32'h0C, 32'h0, "w_rdC_b2b");
    check("w_rdC_const", {HREADYOUT, HRESP, HRDATA}, {2'b10, 32'h12345678});

    // Illegal transfers, including back-to-back ERROR responses
    issue(1, 2'b10, 1, 3'b010, 32'h10, 32'hCAFEF00D, "w_wr10");
    issue(1, 2'b10, 1, 3'b011, 32'h10, 32'h11111111, "err_size");
    issue(1, 2'b10, 1, 3'b001, 32'h01, 32'h22222222, "err_align");
    issue(1, 2'b10, 1, 3'b010, 32'(4*MW), 32'h33333333, "err_range");
    issue(1, 2'b10, 0, 3'b010, 32'h10, 32'h0, "rd10_after_err");
    check("rd10_const", {HREADYOUT, HRESP, HRDATA}, {2'b10, 32'hCAFEF00D});
    issue(1, 2'b10, 0, 3'b010, 32'h00, 32'h0, "rd0_after_err");
    check("rd0_const", {HREADYOUT, HRESP, HRDATA}, {2'b10, 32'h000000AA});

    // No-transfer cases must not touch memory
    issue(1, 2'b00, 1, 3'b010, 32'h04, 32'h0, "idle_wr");
    issue(1, 2'b01, 1, 3'b010, 32'h04, 32'h0, "busy_wr");
    issue(0, 2'b10, 1, 3'b010, 32'h04, 32'h0, "nosel_wr");
    pend_wdata = 32'hA5A5A5A5;
    idle("idle_data");
    issue(1, 2'b10, 0, 3'b010, 32'h04, 32'h0, "rd4_after_idle");
    check("rd4_idle_const", {HREADYOUT, HRESP, HRDATA}, {2'b10, 32'h0000FFFF});

    // Reset during a write data phase aborts the write and clears memory
    issue(1, 2'b10, 1, 3'b010, 32'h20, 32'hFEEDFACE, "w_wr20");
    HSEL = 0; HTRANS = 2'b00; HWDATA = 32'hFEEDFACE; HRESETn = 1'b0;
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    model_clear();
    check("midreset_out", {HREADYOUT, HRESP, HRDATA}, {2'b10, 32'h0});
    issue(1, 2'b10, 0, 3'b010, 32'h20, 32'h0, "rd20_after_reset");
    issue(1, 2'b10, 0, 3'b010, 32'h0C, 32'h0, "rdC_after_reset");
    check("rdC_reset_const", {HREADYOUT, HRESP, HRDATA}, {2'b10, 32'h0});

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      k  = $urandom_range(0, 9);
      sz = (k == 9) ? 3'd3 : 3'(k % 3);
      k  = $urandom_range(0, 9);
      if (k == 0)      ad = $urandom;
      else if (k == 1) ad = 32'($urandom_range(0, 4*MW + 7));
      else begin
        ad = 32'($urandom_range(0, 4*MW - 1));
        if (sz <= 3'd2) ad = ad & ~((32'd1 << sz) - 32'd1);
      end
      issue($urandom_range(0, 7) != 0, 2'($urandom), 1'($urandom), sz, ad, $urandom,
            $sformatf("rnd%0d", i));
    end
    idle("flush");
    for (int w = 0; w < MW; w++) begin
      issue(1, 2'b10, 0, 3'b010, 32'(4*w), 32'h0, $sformatf("sweep%0d", w));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_lite_slave.md
AHB_LITE_SLAVE -- requirements
Module: ahb_lite_slave

Interface
REQ-001 SHALL provide parameter: MEM_WORDS, default 64, depth of internal 32-bit word memory (byte capacity 4*MEM_WORDS).
REQ-002 SHALL use one clock; reset is synchronous and active-low; ports HCLK and HRESETn.
REQ-003 SHALL have ports, in order:
 HCLK  input  1  rising-edge clock
 HRESETn  input  1  synchronous active-low reset
 HSEL  input  1  slave select
 HADDR  input  32  byte address
 HWRITE  input  1  1=write, 0=read
 HSIZE  input  3  000 byte, 001 halfword, 010 word
 HBURST  input  3  accepted, ignored
 HPROT  input  4  accepted, ignored
 HTRANS  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
 HMASTLOCK  input  1  accepted, ignored
 HREADY  input  1  bus ready (system ties to HREADYOUT)
 HWDATA  input  32  write data, data phase
 HREADYOUT  output  1  slave ready
 HRESP  output  1  0 OKAY, 1 ERROR
 HRDATA  output  32  read data, data phase

Function
REQ-004 SHALL accept an address phase on a rising edge when HSEL=1, HREADY=1 and HTRANS is NONSEQ or SEQ; then register HADDR, HWRITE, HSIZE and a valid flag.
REQ-005 SHALL treat IDLE, BUSY, or HSEL=0 as no transfer: OKAY, zero wait, no memory access.
REQ-006 SHALL complete every legal transfer with zero wait states: HREADYOUT=1, HRESP=0 in the data phase (the cycle after acceptance).
REQ-007 SHALL define a legal transfer as HSIZE<=010, address aligned to size (halfword ADDR[0]=0, word ADDR[1:0]=00), and word index HADDR[31:2] < MEM_WORDS.
REQ-008 SHALL, for writes, update memory at the end of the data phase using HWDATA lanes selected by registered address and size, little-endian: byte lane n = bits [8n+7:8n] with n=ADDR[1:0]; halfword lanes [15:0] (ADDR[1]=0) or [31:16] (ADDR[1]=1); word all lanes; unselected bytes unchanged.
REQ-009 SHALL, for reads, drive HRDATA = full memory word at the registered word index during the data phase; master extracts lanes; HRDATA=0 in all other cycles.
REQ-010 SHALL return the newly written value for a read in the phase immediately following a write data phase to the same address (no stale read).
REQ-011 SHALL answer an illegal transfer with a two-cycle ERROR: cycle 1 HREADYOUT=0, HRESP=1; cycle 2 HREADYOUT=1, HRESP=1; no memory write; HRDATA=0.
REQ-012 SHALL ignore address-phase signals in error cycle 1 (HREADY low) and accept a new address phase in error cycle 2 per REQ-004.
REQ-013 SHALL implement data-phase states OKAY_IDLE, ERR1, ERR2: ERR1 always -> ERR2; ERR2 -> ERR1 if a new illegal transfer is accepted, otherwise OKAY_IDLE.

Reset
REQ-014 SHALL, while HRESETn=0 at a rising edge, set HREADYOUT=1, HRESP=0, HRDATA=0, clear the pending-transfer flag and error state, and clear all memory words to 0.
REQ-015 SHALL abort any transfer in progress when reset is asserted mid-transfer, without completing its memory write.

Verification
REQ-016 Reset: HRESETn=0 one cycle -> HREADYOUT=1, HRESP=0, HRDATA=0x00000000; read word 0x00 -> 0x00000000.
REQ-017 NONSEQ halfword write 0x00, HWDATA 0x000000AA; then byte read 0x02 -> OKAY, zero wait, HRDATA=0x000000AA (lane [23:16]=0x00); word read 0x00 -> 0x000000AA.
REQ-018 Word write 0x04 data 0x0000FFFF; byte write 0x08 data 0x000000AA; byte write 0x09 data 0x00005500 -> word reads 0x04=0x0000FFFF, 0x08=0x000055AA.
REQ-019 Back-to-back word write 0x0C data 0x12345678 followed immediately by read 0x0C -> HRDATA=0x12345678 in the read data phase.
REQ-020 HSIZE=011 at 0x10, halfword at 0x01, and word at 4*MEM_WORDS -> each ERROR sequence (0/1 then 1/1); subsequent reads show memory unchanged.
REQ-021 HTRANS=IDLE or BUSY, or HSEL=0 with write -> HREADYOUT=1, HRESP=0, memory unchanged.
